// File: rtl/alu_compare_pipe.sv
// Two-stage valid/ready comparator: S1 registers the operand beat, S2 registers {gt, lt, eq, cond}.
// A saturating counter tracks delivered results whose selected relation held.
module alu_compare_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       mode,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       result,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [2:0] MODE_EQ  = 3'b000;
  localparam logic [2:0] MODE_NE  = 3'b001;
  localparam logic [2:0] MODE_LT  = 3'b010;
  localparam logic [2:0] MODE_LE  = 3'b011;
  localparam logic [2:0] MODE_GT  = 3'b100;
  localparam logic [2:0] MODE_GE  = 3'b101;
  localparam logic [2:0] MODE_ONE = 3'b110;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  function automatic logic [3:0] cmp_flags(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [2:0]       m,
                                           input logic             s);
    logic [WIDTH-1:0] ua;
    logic [WIDTH-1:0] ub;
    logic             eq;
    logic             lt;
    logic             gt;
    logic             cond;
    ua   = {a[WIDTH-1] ^ s, a[WIDTH-2:0]};
    ub   = {b[WIDTH-1] ^ s, b[WIDTH-2:0]};
    eq   = (a == b);
    lt   = (ua < ub);
    gt   = ~eq & ~lt;
    case (m)
      MODE_EQ:  cond = eq;
      MODE_NE:  cond = ~eq;
      MODE_LT:  cond = lt;
      MODE_LE:  cond = lt | eq;
      MODE_GT:  cond = gt;
      MODE_GE:  cond = gt | eq;
      MODE_ONE: cond = 1'b1;
      default:  cond = 1'b0;
    endcase
    return {gt, lt, eq, cond};
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       mode_q, mode_d;
  logic             sgn_q, sgn_d;
  logic             s2_valid_q, s2_valid_d;
  logic [3:0]       result_q, result_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  logic s1_adv;
  logic s2_adv;
  logic fire_in;
  logic fire_out;

  // Handshake and next-state logic for both stages and the hit counter.
  always_comb begin
    s2_adv   = ~s2_valid_q | out_ready;
    s1_adv   = ~s1_valid_q | s2_adv;
    fire_in  = in_valid & s1_adv;
    fire_out = s2_valid_q & out_ready;

    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    sgn_d      = sgn_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    hit_cnt_d  = hit_cnt_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // Operands are only sampled on an accepted beat.
    if (fire_in) begin
      a_d    = op_a;
      b_d    = op_b;
      mode_d = mode;
      sgn_d  = sgn;
    end else begin
      a_d    = a_q;
      b_d    = b_q;
      mode_d = mode_q;
      sgn_d  = sgn_q;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = cmp_flags(a_q, b_q, mode_q, sgn_q);
      end else begin
        result_d = result_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
    end

    // A clear in the same cycle as a hit discards that hit.
    if (cnt_clr) begin
      hit_cnt_d = {CNT_W{1'b0}};
    end else if (fire_out && result_q[0] && (hit_cnt_q != CNT_MAX)) begin
      hit_cnt_d = hit_cnt_q + CNT_ONE;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      mode_q     <= 3'b000;
      sgn_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= 4'b0000;
      hit_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      sgn_q      <= sgn_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_alu_compare_pipe.sv
// Directed bench for alu_compare_pipe with a scoreboard queue of expected flag words.
module tb_alu_compare_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic [2:0] mode = 3'b000;
  logic       sgn = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] result;
  logic       cnt_clr = 1'b0;
  logic [7:0] hit_cnt;

  logic       c_in_valid = 1'b0;
  logic       c_in_ready;
  logic [7:0] c_op_a = 8'h00;
  logic [7:0] c_op_b = 8'h00;
  logic [2:0] c_mode = 3'b000;
  logic       c_out_valid;
  logic [3:0] c_result;
  logic       c_cnt_clr = 1'b0;
  logic [1:0] c_hit_cnt;

  int         n_assert = 0;
  int         n_fail = 0;
  int         n_deliv = 0;
  logic [3:0] exp_q[$];
  logic [7:0] exp_cnt = 8'd0;

  alu_compare_pipe #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .mode(mode), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
  );

  alu_compare_pipe #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .op_a(c_op_a), .op_b(c_op_b), .mode(c_mode), .sgn(1'b0),
    .out_valid(c_out_valid), .out_ready(1'b1), .result(c_result),
    .cnt_clr(c_cnt_clr), .hit_cnt(c_hit_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] m, input logic s);
    int   ia;
    int   ib;
    logic eq;
    logic lt;
    logic gt;
    logic c;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    eq = (ia == ib);
    lt = (ia < ib);
    gt = (ia > ib);
    case (m)
      3'd0:    c = eq;
      3'd1:    c = !eq;
      3'd2:    c = lt;
      3'd3:    c = lt || eq;
      3'd4:    c = gt;
      3'd5:    c = gt || eq;
      3'd6:    c = 1'b1;
      default: c = 1'b0;
    endcase
    return {gt, lt, eq, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m, input logic s);
    op_a = a; op_b = b; mode = m; sgn = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] m, input logic s, input logic [3:0] exp);
    beat(a, b, m, s);
    check({tag, "_early"}, out_valid, 1'b0);
    tick();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_result"}, result, exp);
    tick();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: push on accepted beat, pop and compare on delivery, track the hit count.
  initial begin
    logic [3:0] e;
    logic       popped_hit;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_cnt = 8'd0;
      end else begin
        check("hit_cnt", hit_cnt, exp_cnt);
        popped_hit = 1'b0;
        if (out_valid && out_ready) begin
          n_deliv++;
          if (exp_q.size() == 0) begin
            check("unexpected_out", out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("sb_result", result, e);
            popped_hit = e[0];
          end
        end
        if (cnt_clr) exp_cnt = 8'd0;
        else if (popped_hit && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        if (in_valid && in_ready) exp_q.push_back(model(op_a, op_b, mode, sgn));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required below 100000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int         n0;
    int         k;
    logic       rdy;
    logic [7:0] bp_a[4];
    logic [7:0] bp_b[4];
    logic [2:0] bp_m[4];
    logic [3:0] held;

    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 4'b0000);
    check("rst_hit_cnt", hit_cnt, 8'd0);
    check("rst_sat_hit_cnt", c_hit_cnt, 2'd0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    directed("eq_same",  8'h5A, 8'h5A, 3'b000, 1'b0, 4'b0011);
    directed("eq_diff",  8'h5A, 8'h5B, 3'b000, 1'b0, 4'b0100);
    directed("lt_sgn",   8'hFF, 8'h01, 3'b010, 1'b1, 4'b0101);
    directed("lt_usgn",  8'hFF, 8'h01, 3'b010, 1'b0, 4'b1000);
    directed("ge_sgnmin", 8'h80, 8'h7F, 3'b101, 1'b1, 4'b0100);
    directed("rsvd",     8'h10, 8'h10, 3'b111, 1'b0, 4'b0010);

    // Streaming: 16 back-to-back beats, results one per cycle from cycle 2.
    n0 = n_deliv;
    for (int i = 0; i < 19; i++) begin
      if (i < 16) begin
        op_a = 8'($urandom_range(0, 255));
        op_b = ($urandom_range(0, 3) == 0) ? op_a : 8'($urandom_range(0, 255));
        mode = 3'($urandom_range(0, 7));
        sgn  = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        check("stream_in_ready", in_ready, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      check("stream_out_valid", out_valid, (i >= 2 && i < 18) ? 1'b1 : 1'b0);
      tick();
    end
    check("stream_count", n_deliv - n0, 16);
    check("stream_hit_cnt", hit_cnt, exp_cnt);

    // Backpressure: pipe fills two deep, result holds, nothing lost on release.
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 8'(8'h30 + 8'(i));
      bp_b[i] = 8'h31;
      bp_m[i] = 3'(i + 2);
    end
    held = model(bp_a[0], bp_b[0], bp_m[0], 1'b0);
    out_ready = 1'b0;
    n0 = n_deliv;
    k = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      op_a = bp_a[k]; op_b = bp_b[k]; mode = bp_m[k]; sgn = 1'b0;
      in_valid = 1'b1;
      if (cyc >= 2) check("bp_hold", result, held);
      rdy = in_ready;
      tick();
      if (rdy) k++;
    end
    check("bp_accepts", k, 2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_result", result, held);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    for (int n = 0; n < 10 && k < 4; n++) begin
      op_a = bp_a[k]; op_b = bp_b[k]; mode = bp_m[k];
      in_valid = 1'b1;
      rdy = in_ready;
      tick();
      if (rdy) k++;
    end
    in_valid = 1'b0;
    drain("bp_drain");
    check("bp_count", n_deliv - n0, 4);

    // Saturating counter with CNT_W=2.
    for (int i = 0; i < 5; i++) begin
      c_op_a = 8'(i); c_op_b = 8'(i); c_mode = 3'b000;
      c_in_valid = 1'b1;
      tick();
    end
    c_in_valid = 1'b0;
    repeat (3) tick();
    check("sat_hit_cnt", c_hit_cnt, 2'd3);
    c_op_a = 8'h22; c_op_b = 8'h22; c_mode = 3'b110;
    c_in_valid = 1'b1;
    tick();
    c_in_valid = 1'b0;
    tick();
    check("clr_hit_valid", c_out_valid, 1'b1);
    check("clr_hit_cond", c_result[0], 1'b1);
    c_cnt_clr = 1'b1;
    tick();
    c_cnt_clr = 1'b0;
    check("clr_wins", c_hit_cnt, 2'd0);
    tick();
    check("clr_stays", c_hit_cnt, 2'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    beat(8'h01, 8'h01, 3'b000, 1'b0);
    beat(8'h02, 8'h02, 3'b110, 1'b0);
    check("mid_full_valid", out_valid, 1'b1);
    check("mid_full_ready", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_result", result, 4'b0000);
    check("mid_rst_hit", hit_cnt, 8'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    directed("post_rst", 8'h7F, 8'h80, 3'b100, 1'b1, 4'b1001);
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
